// File: rtl/cpu_pkg.sv
// Shared definitions for the AZ core: datapath widths, control-op and
// exception codes, and control register addresses.
package cpu_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam int REG_ADDR_W  = 5;

  localparam logic [1:0] CTRL_OP_NOP  = 2'd0;
  localparam logic [1:0] CTRL_OP_WRCR = 2'd1;
  localparam logic [1:0] CTRL_OP_EXRT = 2'd2;

  localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
  localparam logic [2:0] ISA_EXP_EXT_INT    = 3'd1;
  localparam logic [2:0] ISA_EXP_UNDEF_INSN = 3'd2;
  localparam logic [2:0] ISA_EXP_OVERFLOW   = 3'd3;
  localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;
  localparam logic [2:0] ISA_EXP_TRAP       = 3'd5;
  localparam logic [2:0] ISA_EXP_PRV_VIO    = 3'd6;

  localparam logic [REG_ADDR_W-1:0] CREG_STATUS     = 5'd0;
  localparam logic [REG_ADDR_W-1:0] CREG_PRE_STATUS = 5'd1;
  localparam logic [REG_ADDR_W-1:0] CREG_EPC        = 5'd2;
  localparam logic [REG_ADDR_W-1:0] CREG_VECTOR     = 5'd3;
  localparam logic [REG_ADDR_W-1:0] CREG_CAUSE      = 5'd4;
  localparam logic [REG_ADDR_W-1:0] CREG_MASK       = 5'd5;
  localparam logic [REG_ADDR_W-1:0] CREG_IRQ        = 5'd6;

  typedef struct packed {
    logic int_en;
    logic exe_mode;
  } status_t;

endpackage

// File: rtl/creg_file.sv
// Control register file: STATUS/PRE_STATUS/EPC/VECTOR/CAUSE/MASK with a
// combinational read port and exception / EXRT / WRCR update paths.
module creg_file
  import cpu_pkg::*;
#(
  parameter int                     IRQ_W     = 8,
  parameter logic [WORD_ADDR_W-1:0] VEC_RESET = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IRQ_W-1:0]       irq,
  input  logic [REG_ADDR_W-1:0]  rd_addr,
  output logic [WORD_DATA_W-1:0] rd_data,
  input  logic                   exp_commit,
  input  logic                   exrt_commit,
  input  logic                   wr_en,
  input  logic [REG_ADDR_W-1:0]  wr_addr,
  input  logic [WORD_DATA_W-1:0] wr_data,
  input  logic [2:0]             exp_code,
  input  logic                   br_flag,
  input  logic [WORD_ADDR_W-1:0] pc,
  output logic [WORD_ADDR_W-1:0] epc,
  output logic [WORD_ADDR_W-1:0] vector,
  output logic [IRQ_W-1:0]       mask,
  output logic                   int_en,
  output logic                   exe_mode
);

  status_t    status;
  status_t    pre_status;
  logic [3:0] cause;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of its peers (PRE_STATUS <= STATUS swap).
  always_ff @(posedge clk) begin
    if (reset) begin
      status     <= '0;
      pre_status <= '0;
      epc        <= '0;
      vector     <= VEC_RESET;
      cause      <= '0;
      mask       <= '1;
    end else if (exp_commit) begin
      pre_status <= status;
      status     <= '0;
      cause      <= {br_flag, exp_code};
      // A faulting delay-slot instruction restarts at its branch.
      epc        <= br_flag ? pc - WORD_ADDR_W'(1) : pc;
    end else if (exrt_commit) begin
      status <= pre_status;
    end else if (wr_en) begin
      case (wr_addr)
        CREG_STATUS:     status     <= status_t'(wr_data[1:0]);
        CREG_PRE_STATUS: pre_status <= status_t'(wr_data[1:0]);
        CREG_EPC:        epc        <= wr_data[WORD_DATA_W-1:2];
        CREG_VECTOR:     vector     <= wr_data[WORD_DATA_W-1:2];
        CREG_CAUSE:      cause      <= wr_data[3:0];
        CREG_MASK:       mask       <= wr_data[IRQ_W-1:0];
        default:         ;
      endcase
    end
  end

  // NOTE: the default assignment ahead of the case keeps this purely
  // combinational for unmapped addresses (no latch).
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CREG_STATUS:     rd_data = WORD_DATA_W'(status);
      CREG_PRE_STATUS: rd_data = WORD_DATA_W'(pre_status);
      CREG_EPC:        rd_data = {epc, 2'b00};
      CREG_VECTOR:     rd_data = {vector, 2'b00};
      CREG_CAUSE:      rd_data = WORD_DATA_W'(cause);
      CREG_MASK:       rd_data = WORD_DATA_W'(mask);
      CREG_IRQ:        rd_data = WORD_DATA_W'(irq);
      default:         ;
    endcase
  end

  assign int_en   = status.int_en;
  assign exe_mode = status.exe_mode;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the AZ core: per-stage stall/flush, interrupt
// detection, and MEM-stage commit of exceptions, EXRT and WRCR.
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int                     IRQ_W     = 8,
  parameter logic [WORD_ADDR_W-1:0] VEC_RESET = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IRQ_W-1:0]       irq,
  input  logic                   if_busy,
  input  logic                   mem_busy,
  input  logic                   ld_hazard,
  input  logic [REG_ADDR_W-1:0]  creg_rd_addr,
  output logic [WORD_DATA_W-1:0] creg_rd_data,
  input  logic [WORD_ADDR_W-1:0] mem_pc,
  input  logic                   mem_en,
  input  logic                   mem_br_flag,
  input  logic [1:0]             mem_ctrl_op,
  input  logic [REG_ADDR_W-1:0]  mem_dst_addr,
  input  logic [2:0]             mem_exp_code,
  input  logic [WORD_DATA_W-1:0] mem_out,
  output logic                   if_stall,
  output logic                   id_stall,
  output logic                   ex_stall,
  output logic                   mem_stall,
  output logic                   if_flush,
  output logic                   id_flush,
  output logic                   ex_flush,
  output logic                   mem_flush,
  output logic [WORD_ADDR_W-1:0] new_pc,
  output logic                   int_detect,
  output logic                   exe_mode
);

  logic                   stall;
  logic                   commit;
  logic                   exp_commit;
  logic                   exrt_commit;
  logic                   wr_en;
  logic                   redirect;
  logic                   int_en;
  logic [IRQ_W-1:0]       mask;
  logic [WORD_ADDR_W-1:0] epc;
  logic [WORD_ADDR_W-1:0] vector;

  assign stall = if_busy | mem_busy;

  // A stalled MEM instruction waits; reset discards any pending commit.
  assign commit      = mem_en & ~stall & ~reset;
  assign exp_commit  = commit & (mem_exp_code != ISA_EXP_NO_EXP);
  assign exrt_commit = commit & ~exp_commit & (mem_ctrl_op == CTRL_OP_EXRT);
  assign wr_en       = commit & ~exp_commit & (mem_ctrl_op == CTRL_OP_WRCR);
  assign redirect    = exp_commit | exrt_commit;

  // Redirect overrides the load-use hold so IF fetches the new target.
  assign if_stall  = stall | (ld_hazard & ~redirect);
  assign id_stall  = stall;
  assign ex_stall  = stall;
  assign mem_stall = stall;

  assign if_flush  = redirect;
  assign id_flush  = redirect | (ld_hazard & ~stall);
  assign ex_flush  = redirect;
  assign mem_flush = redirect;

  always_comb begin
    new_pc = '0;
    if (exp_commit)       new_pc = vector;
    else if (exrt_commit) new_pc = epc;
  end

  assign int_detect = int_en & (|(irq & ~mask));

  creg_file #(
    .IRQ_W     (IRQ_W),
    .VEC_RESET (VEC_RESET)
  ) u_creg_file (
    .clk         (clk),
    .reset       (reset),
    .irq         (irq),
    .rd_addr     (creg_rd_addr),
    .rd_data     (creg_rd_data),
    .exp_commit  (exp_commit),
    .exrt_commit (exrt_commit),
    .wr_en       (wr_en),
    .wr_addr     (mem_dst_addr),
    .wr_data     (mem_out),
    .exp_code    (mem_exp_code),
    .br_flag     (mem_br_flag),
    .pc          (mem_pc),
    .epc         (epc),
    .vector      (vector),
    .mask        (mask),
    .int_en      (int_en),
    .exe_mode    (exe_mode)
  );

endmodule
